rng_arbiter: RTL and testbench

Shares one `rng` byte-accumulator instance among `NUM_REQ` TPM command engines. Requesters are served round-robin. For each grant the block pulses `rng` start, waits for its one-cycle `valid`, and returns the `8*BYTES`-bit result to the granted requester with a one-cycle acknowledge. A watchdog recovers a stalled generator. An optional repeat-count health test rejects stuck output.

---
 rtl/rng_arb_pkg.sv | 30 +++
 rtl/rr_priority_sel.sv | 21 ++
 rtl/rng_arbiter.sv | 134 +++++++++++++
 tb/tb_rng_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rng_arb_pkg.sv
// rng_arb_pkg: shared state encoding, repeat limit and round-robin pick helper
// for rng_arbiter.
package rng_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DELIVER = 3'd3,
        ST_RECOVER = 3'd4
    } rng_arb_state_t;

    localparam int RNG_ARB_MAX_REPEAT = 3;

    // Returns {found, idx}: first set request searching upward from last_gnt+1 with wrap over n.
    function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] last_gnt, input int n = 8);
        logic [3:0] r;
        logic [3:0] j;
        r = '0;
        for (int k = 1; k <= 8; k++) begin
            j = {1'b0, last_gnt} + 4'(k);
            if (j >= 4'(n))
                j = j - 4'(n);
            if (k <= n && !r[3] && req[j[2:0]])
                r = {1'b1, j[2:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// rr_priority_sel: combinational round-robin selector returning the next
// requester index after i_last and whether any request is pending.
module rr_priority_sel
    import rng_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    logic [3:0] w_pick;

    assign w_pick  = rr_pick(8'(i_req), 3'(i_last), N);
    assign o_idx   = IW'(w_pick[2:0]);
    assign o_found = w_pick[3];

endmodule

// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin sharing of one rng byte accumulator with watchdog recovery.
// Define RNG_ARB_REPEAT_CHECK_EN to reject consecutive identical results.
module rng_arbiter
    import rng_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int BYTES          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   ack,
    output logic [8*BYTES-1:0]   rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 rng_start,
    output logic                 rng_rst,
    input  logic [8*BYTES-1:0]   rng_result,
    input  logic                 rng_valid
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    rng_arb_state_t     r_state;
    logic [IW-1:0]      r_gnt;
    logic [IW-1:0]      r_last;
    logic [WW-1:0]      r_wdog;
    logic [8*BYTES-1:0] r_result;
    logic [IW-1:0]      w_idx;
    logic               w_found;
`ifdef RNG_ARB_REPEAT_CHECK_EN
    logic [8*BYTES-1:0] r_prev;
    logic               r_prev_valid;
    logic [1:0]         r_rep;
`endif

    rr_priority_sel #(.N(NUM_REQ), .IW(IW)) u_sel (
        .i_req   (req),
        .i_last  (r_last),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_last    <= IW'(NUM_REQ - 1);
            r_wdog    <= '0;
            r_result  <= '0;
            ack       <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rng_start <= 1'b0;
            rng_rst   <= 1'b0;
`ifdef RNG_ARB_REPEAT_CHECK_EN
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_rep        <= '0;
`endif
        end else begin
            ack       <= '0;
            rng_start <= 1'b0;
            rng_rst   <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_found) begin
                    r_gnt     <= w_idx;
                    rng_start <= 1'b1;
                    r_state   <= ST_START;
`ifdef RNG_ARB_REPEAT_CHECK_EN
                    r_rep     <= '0;
`endif
                end
                ST_START: begin
                    r_wdog  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: if (rng_valid) begin
`ifdef RNG_ARB_REPEAT_CHECK_EN
                    // A stuck generator repeats itself; retry, then give up on the third repeat.
                    if (r_prev_valid && rng_result == r_prev) begin
                        if (r_rep == 2'(RNG_ARB_MAX_REPEAT - 1))
                            r_state <= ST_RECOVER;
                        else begin
                            r_rep     <= r_rep + 2'd1;
                            rng_start <= 1'b1;
                            r_state   <= ST_START;
                        end
                    end else begin
                        r_result <= rng_result;
                        r_state  <= ST_DELIVER;
                    end
`else
                    r_result <= rng_result;
                    r_state  <= ST_DELIVER;
`endif
                end else if (r_wdog == WW'(TIMEOUT_CYCLES - 1))
                    r_state <= ST_RECOVER;
                else
                    r_wdog <= r_wdog + 1'b1;
                ST_DELIVER: begin
                    if (req[r_gnt]) begin
                        ack[r_gnt] <= 1'b1;
                        rsp_data   <= r_result;
                        rsp_err    <= 1'b0;
`ifdef RNG_ARB_REPEAT_CHECK_EN
                        r_prev       <= r_result;
                        r_prev_valid <= 1'b1;
`endif
                    end
                    r_last  <= r_gnt;
                    r_state <= ST_IDLE;
                end
                ST_RECOVER: begin
                    rng_rst    <= 1'b1;
                    ack[r_gnt] <= 1'b1;
                    rsp_err    <= 1'b1;
                    rsp_data   <= '0;
                    r_last     <= r_gnt;
                    r_state    <= ST_IDLE;
`ifdef RNG_ARB_REPEAT_CHECK_EN
                    r_prev_valid <= 1'b0;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: directed bench with an rng latency model and an expected-ack scoreboard.
module tb_rng_arbiter;

    typedef struct {
        int          idx;
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  ack;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        rng_start;
    logic        rng_rst;
    logic [63:0] rng_result = '0;
    logic        rng_valid = 1'b0;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_start;
    int          st_cyc;
    int          ack_cyc;
    bit          m_stall = 1'b0;
    logic [63:0] m_val = '0;
    int          m_cnt = 0;

    localparam logic [63:0] AA = 64'hAAAA_AAAA_AAAA_AAAA;

    rng_arbiter #(.NUM_REQ(4), .BYTES(8), .TIMEOUT_CYCLES(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .ack        (ack),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .rng_start  (rng_start),
        .rng_rst    (rng_rst),
        .rng_result (rng_result),
        .rng_valid  (rng_valid)
    );

    always #5 clk = ~clk;

    // rng model: valid is sampled by the arbiter 10 cycles after it samples start.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt     <= 0;
            rng_valid <= 1'b0;
        end else begin
            if (rng_start)
                m_cnt <= 9;
            else if (m_cnt != 0)
                m_cnt <= m_cnt - 1;
            rng_valid <= !m_stall && !rng_start && m_cnt == 1;
            if (!m_stall && !rng_start && m_cnt == 1)
                rng_result <= m_val;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input int idx, input logic [63:0] d, input logic e);
        exp_q.push_back('{idx, d, e});
    endfunction

    // Waits for the next ack, compares it against the scoreboard head.
    task automatic serve(input bit drop, input int budget);
        int   cyc;
        bit   done;
        int   idx;
        exp_t e;
        cyc = 0;
        done = 1'b0;
        n_start = 0;
        st_cyc = -1;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (rng_start) begin
                n_start++;
                if (st_cyc < 0) st_cyc = cyc;
            end
            if (ack != 0) begin
                done = 1'b1;
                ack_cyc = cyc;
                idx = -1;
                for (int b = 0; b < 4; b++) if (ack[b]) idx = b;
                check("ack_onehot", 64'($onehot(ack)), 1);
                check("busy_at_ack", busy, 0);
                check("sb_nonempty", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("ack_idx", 64'(idx), 64'(e.idx));
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_err", rsp_err, e.err);
                    check("rng_rst", rng_rst, e.err);
                end
                if (drop) req = req & ~ack;
            end
        end
        check("ack_budget", done, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit seen;
        @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_start", rng_start, 0);
        check("rst_rng_rst", rng_rst, 0);
        check("rst_err", rsp_err, 0);
        check("rst_data", rsp_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single requester, nominal latency
        m_val = 64'h0123_4567_89AB_CDEF;
        push(2, m_val, 1'b0);
        req = 4'b0100;
        serve(1, 40);
        check("single_latency", 64'(ack_cyc), 13);
        check("single_starts", 64'(n_start), 1);
        req = '0;

        // fairness with all requests held
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            m_val = 64'hF000 + 64'(k);
            push(k % 4, m_val, 1'b0);
            serve(0, 40);
        end
        req = '0;

        // watchdog timeout
        do_reset();
        m_stall = 1'b1;
        push(0, 64'h0, 1'b1);
        req = 4'b0001;
        serve(1, 100);
        check("timeout_latency", 64'(ack_cyc - st_cyc), 66);
        m_stall = 1'b0;
        req = '0;

        // abandon: req[1] drops during WAIT, req[3] served next, then 0
        m_val = 64'hB3B3_0000_0000_0003;
        req = 4'b1010;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack != 0) seen = 1'b1;
        end
        check("abandon_busy", busy, 1);
        req = 4'b1000;
        push(3, m_val, 1'b0);
        serve(1, 60);
        check("abandon_no_early_ack", seen, 0);
        m_val = 64'h0B0B_0000_0000_0000;
        req = 4'b1001;
        push(0, m_val, 1'b0);
        serve(1, 40);
        req = '0;

        // repeated identical results
        m_val = AA;
        req = 4'b0010;
        push(1, AA, 1'b0);
        serve(1, 60);
        req = 4'b0010;
`ifdef RNG_ARB_REPEAT_CHECK_EN
        push(1, 64'h0, 1'b1);
        serve(1, 120);
        check("repeat_starts", 64'(n_start), 3);
`else
        push(1, AA, 1'b0);
        serve(1, 60);
        check("repeat_starts", 64'(n_start), 1);
`endif
        req = '0;

        // async reset mid-WAIT
        m_val = 64'hC0C0_C0C0_0000_0001;
        req = 4'b0100;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (rng_start) seen = 1'b1;
        end
        check("arst_saw_start", seen, 1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ack", ack, 0);
        check("arst_busy", busy, 0);
        check("arst_err", rsp_err, 0);
        check("arst_data", rsp_data, 0);
        check("arst_start", rng_start, 0);
        check("arst_rng_rst", rng_rst, 0);
        @(negedge clk);
        req = 4'b0101;
        @(negedge clk);
        rst_n = 1'b1;
        push(0, m_val, 1'b0);
        serve(1, 40);
        check("arst_latency", 64'(ack_cyc), 13);
        req = '0;
        repeat (20) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
